// File: rtl/ifid_hazard_stage.sv
// IF/ID pipeline register with load-use hazard detection and redirect flush.
// It holds the fetched instruction and its word PC for decode. For one cycle it
// stalls a consumer that reads the destination of a load sitting in ID/EX. On a
// taken redirect it flushes itself to a NOP. Two saturating debug counters record
// the stalls and the flushes.
//
// Handshake: pc_hold is a combinational stall request to fetch. While it is high,
// fetch must keep its PC and instr_in/pc_in on the following edge. IF/ID also
// ignores them on that edge. idex_bubble is asserted in the same cycle and tells
// ID/EX to load a NOP on the same edge.
module ifid_hazard_stage #(
  parameter int          COUNT_W  = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr_in,
  input  logic [29:0]        pc_in,
  input  logic               fetch_valid,
  input  logic               idex_memRead,
  input  logic [4:0]         idex_rt,
  input  logic               redirect,
  output logic [31:0]        instr_out,
  output logic [29:0]        pc_out,
  output logic               valid_out,
  output logic               pc_hold,
  output logic               idex_bubble,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count,
  output logic               fsm_state
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  state_t     state;
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       hazard;

  assign op = instr_out[31:26];
  assign rs = instr_out[25:21];
  assign rt = instr_out[20:16];

  // The rt field is a source only for R-type, beq, bne and sw.
  always_comb begin
    uses_rt = 1'b0;
    case (op)
      6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;
      default:                    uses_rt = 1'b0;
    endcase
  end

  // Load-use detection. It is masked in STALL so an occupant stalls at most once.
  always_comb begin
    hazard = 1'b0;
    if (state == RUN && valid_out && idex_memRead && idex_rt != 5'd0 &&
        (idex_rt == rs || (uses_rt && idex_rt == rt)))
      hazard = 1'b1;
  end

  assign pc_hold     = hazard;
  assign idex_bubble = hazard;
  assign fsm_state   = (state == STALL);

  // Pipeline register, stall/flush FSM and saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      instr_out   <= NOP_WORD;
      pc_out      <= '0;
      valid_out   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (hazard) begin
        // Hold the consumer in place. A redirect seen now used a stale operand and is dropped.
        state <= STALL;
        if (stall_count != '1)
          stall_count <= stall_count + COUNT_W'(1);
      end else begin
        // RUN without a hazard, and every STALL cycle, load the same way.
        state <= RUN;
        if (redirect) begin
          instr_out <= NOP_WORD;
          valid_out <= 1'b0;
          if (flush_count != '1)
            flush_count <= flush_count + COUNT_W'(1);
        end else begin
          instr_out <= fetch_valid ? instr_in : NOP_WORD;
          pc_out    <= pc_in;
          valid_out <= fetch_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Directed bench for ifid_hazard_stage. A default-width instance and a 2-bit
// counter instance share every input. Outputs are sampled 1 time unit after each
// rising edge.
module tb_ifid_hazard_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [29:0] pc_in;
  logic        fetch_valid;
  logic        idex_memRead;
  logic [4:0]  idex_rt;
  logic        redirect;

  logic [31:0] instr_out, s_instr_out;
  logic [29:0] pc_out, s_pc_out;
  logic        valid_out, s_valid_out;
  logic        pc_hold, s_pc_hold;
  logic        idex_bubble, s_idex_bubble;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  s_stall_count, s_flush_count;
  logic        fsm_state, s_fsm_state;

  int checks = 0;
  int errors = 0;

  ifid_hazard_stage dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .fetch_valid(fetch_valid), .idex_memRead(idex_memRead), .idex_rt(idex_rt),
    .redirect(redirect), .instr_out(instr_out), .pc_out(pc_out),
    .valid_out(valid_out), .pc_hold(pc_hold), .idex_bubble(idex_bubble),
    .stall_count(stall_count), .flush_count(flush_count), .fsm_state(fsm_state)
  );

  ifid_hazard_stage #(.COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
    .fetch_valid(fetch_valid), .idex_memRead(idex_memRead), .idex_rt(idex_rt),
    .redirect(redirect), .instr_out(s_instr_out), .pc_out(s_pc_out),
    .valid_out(s_valid_out), .pc_hold(s_pc_hold), .idex_bubble(s_idex_bubble),
    .stall_count(s_stall_count), .flush_count(s_flush_count), .fsm_state(s_fsm_state)
  );

  // Clock: 10-unit period, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [29:0] pc, input logic fv);
    instr_in    = instr;
    pc_in       = pc;
    fetch_valid = fv;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_instr"}, instr_out, 32'h0);
    chk({tag, "_pc"}, 32'(pc_out), 32'h0);
    chk({tag, "_valid"}, 32'(valid_out), 32'h0);
    chk({tag, "_stall_cnt"}, 32'(stall_count), 32'h0);
    chk({tag, "_flush_cnt"}, 32'(flush_count), 32'h0);
    chk({tag, "_pc_hold"}, 32'(pc_hold), 32'h0);
    chk({tag, "_bubble"}, 32'(idex_bubble), 32'h0);
    chk({tag, "_state"}, 32'(fsm_state), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    fetch(32'h0, 30'd0, 1'b0);
    idex_memRead = 1'b0;
    idex_rt      = 5'd0;
    redirect     = 1'b0;
    tick();
    tick();
    chk_reset_values("por");

    // Run with valid data, then assert reset between edges.
    reset = 1'b1;
    fetch(32'h0022_1820, 30'd3, 1'b1);
    tick();
    chk("run_instr", instr_out, 32'h0022_1820);
    chk("run_pc", 32'(pc_out), 32'd3);
    #2 reset = 1'b0;
    #1 chk_reset_values("async_rst");
    #1 reset = 1'b1;
    fetch(32'h8C01_0004, 30'd5, 1'b1);
    tick();
    chk("post_rst_instr", instr_out, 32'h8C01_0004);
    chk("post_rst_pc", 32'(pc_out), 32'd5);
    chk("post_rst_valid", 32'(valid_out), 32'd1);

    // Load-use hazard on rs: add $3,$1,$2 versus a load of $1 in ID/EX.
    fetch(32'h0022_1820, 30'd6, 1'b1);
    tick();
    fetch(32'h0043_2020, 30'd7, 1'b1);
    idex_memRead = 1'b1;
    idex_rt      = 5'd1;
    #1;
    chk("rs_hazard_hold", 32'(pc_hold), 32'd1);
    chk("rs_hazard_bubble", 32'(idex_bubble), 32'd1);
    tick();
    chk("stall_instr_held", instr_out, 32'h0022_1820);
    chk("stall_pc_held", 32'(pc_out), 32'd6);
    chk("stall_state", 32'(fsm_state), 32'd1);
    chk("stall_masked", 32'(pc_hold), 32'd0);
    chk("stall_cnt_1", 32'(stall_count), 32'd1);
    tick();
    chk("after_stall_instr", instr_out, 32'h0043_2020);
    chk("after_stall_pc", 32'(pc_out), 32'd7);
    chk("after_stall_state", 32'(fsm_state), 32'd0);
    chk("no_match_hold", 32'(pc_hold), 32'd0);

    // idex_rt = $0 never stalls, even when it matches rs = $0.
    idex_memRead = 1'b0;
    fetch(32'h0002_1820, 30'd8, 1'b1);
    tick();
    idex_memRead = 1'b1;
    idex_rt      = 5'd0;
    #1 chk("rt_zero_hold", 32'(pc_hold), 32'd0);

    // addi does not read rt, so a match on rt must not stall.
    idex_memRead = 1'b0;
    fetch(32'h2044_0005, 30'd9, 1'b1);
    tick();
    idex_memRead = 1'b1;
    idex_rt      = 5'd4;
    #1 chk("addi_rt_hold", 32'(pc_hold), 32'd0);

    // sw reads rt, so it must stall.
    idex_memRead = 1'b0;
    fetch(32'hAC44_0000, 30'd10, 1'b1);
    tick();
    idex_memRead = 1'b1;
    idex_rt      = 5'd4;
    fetch(32'h0000_0000, 30'd11, 1'b1);
    #1 chk("sw_rt_hold", 32'(pc_hold), 32'd1);
    tick();
    chk("sw_stall_cnt", 32'(stall_count), 32'd2);
    chk("sw_held_instr", instr_out, 32'hAC44_0000);
    idex_memRead = 1'b0;
    tick();
    chk("sw_next_pc", 32'(pc_out), 32'd11);

    // Redirect with no hazard flushes the slot and leaves the PC alone.
    redirect = 1'b1;
    fetch(32'h1111_1111, 30'd20, 1'b1);
    tick();
    redirect = 1'b0;
    chk("flush_instr", instr_out, 32'h0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_pc", 32'(pc_out), 32'd11);
    chk("flush_cnt_1", 32'(flush_count), 32'd1);

    // Hazard and redirect together: the stall wins and no flush is counted.
    fetch(32'h0022_1820, 30'd21, 1'b1);
    tick();
    idex_memRead = 1'b1;
    idex_rt      = 5'd1;
    redirect     = 1'b1;
    fetch(32'h2222_2222, 30'd22, 1'b1);
    #1 chk("both_hold", 32'(pc_hold), 32'd1);
    tick();
    chk("both_instr_held", instr_out, 32'h0022_1820);
    chk("both_valid", 32'(valid_out), 32'd1);
    chk("both_flush_cnt", 32'(flush_count), 32'd1);
    chk("both_stall_cnt", 32'(stall_count), 32'd3);
    redirect     = 1'b0;
    idex_memRead = 1'b0;
    tick();
    chk("both_next_instr", instr_out, 32'h2222_2222);

    // An invalid fetch loads a NOP bubble and leaves both counters unchanged.
    fetch(32'h3333_3333, 30'd23, 1'b0);
    tick();
    chk("fv0_instr", instr_out, 32'h0);
    chk("fv0_valid", 32'(valid_out), 32'd0);
    chk("fv0_stall_cnt", 32'(stall_count), 32'd3);
    chk("fv0_flush_cnt", 32'(flush_count), 32'd1);

    // Two more stalls. The 2-bit counter must stay at 3 while the wide one reaches 5.
    for (int i = 0; i < 2; i++) begin
      fetch(32'h0022_1820, 30'd30, 1'b1);
      idex_memRead = 1'b0;
      tick();
      idex_memRead = 1'b1;
      idex_rt      = 5'd1;
      tick();
      idex_memRead = 1'b0;
      tick();
    end
    chk("sat_stall_cnt", 32'(s_stall_count), 32'd3);
    chk("wide_stall_cnt", 32'(stall_count), 32'd5);
    chk("sat_flush_cnt", 32'(s_flush_count), 32'd1);

    // Reset in the middle of a stall abandons the stall.
    idex_memRead = 1'b1;
    idex_rt      = 5'd1;
    tick();
    chk("mid_stall_state", 32'(fsm_state), 32'd1);
    #2 reset = 1'b0;
    idex_memRead = 1'b0;
    #1 chk_reset_values("stall_rst");
    reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
